uart_tx_scheduler: RTL and testbench

Sequences all outbound UART traffic between the two game boards. It arbitrates three requesters (own-tank position per frame, shot event, status/menu byte) and serialises each into a fixed 6-byte packet. Bytes are pushed into the uart block's transmit FIFO under a write/full handshake. It sits between Tank_Gen/GUI control logic and the uart TX path in the 65 MHz domain.

---
 rtl/uart_tx_scheduler_if.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Request, TX FIFO handshake and status bundle for the UART packet scheduler.
// master = scheduler side, slave = requesters, FIFO and observers.
interface uart_tx_scheduler_if;
  logic       frame_tick;
  logic [9:0] xpos_tank;
  logic [9:0] ypos_tank;
  logic       shot_req;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  logic       status_req;
  logic [7:0] status_in;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       busy;
  logic       pkt_done;
  logic [7:0] drop_cnt;

  modport master (
    input  frame_tick, xpos_tank, ypos_tank, shot_req, shot_x, shot_y,
           status_req, status_in, tx_full,
    output tx_data, tx_wr, busy, pkt_done, drop_cnt
  );

  modport slave (
    output frame_tick, xpos_tank, ypos_tank, shot_req, shot_x, shot_y,
           status_req, status_in, tx_full,
    input  tx_data, tx_wr, busy, pkt_done, drop_cnt
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Arbitrates shot/status/position requests and serialises each into a
// 6-byte packet (SYNC, TYPE, P0, P1, P2, CHK) written into the UART TX FIFO.
//   state  | meaning
//   S_IDLE | waiting for a pending request; loads the winner's packet
//   S_SEND | writing packet bytes, stalls while the FIFO is full
//   S_GAP  | enforced idle time after a packet
module uart_tx_scheduler #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MIN_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_scheduler_if.master bus
);

  localparam int unsigned   GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_pos_pend;
  logic            r_shot_pend;
  logic            r_stat_pend;
  logic [23:0]     r_pos_pl;
  logic [23:0]     r_shot_pl;
  logic [23:0]     r_stat_pl;
  logic [5:0][7:0] r_pkt;
  logic [2:0]      r_idx;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_pkt_done;
  logic [7:0]      r_drop_cnt;

  logic            w_any_pend;
  logic            w_load;
  logic            w_take_shot;
  logic            w_take_stat;
  logic            w_take_pos;
  logic [7:0]      w_type;
  logic [23:0]     w_pl;
  logic [7:0]      w_chk;
  logic            w_wr;
  logic            w_last_wr;
  logic [7:0]      w_tx_data;
  logic [1:0]      w_drop_n;
  logic [8:0]      w_drop_sum;

  assign w_any_pend  = r_pos_pend | r_shot_pend | r_stat_pend;
  assign w_load      = (r_state == S_IDLE) && w_any_pend;
  assign w_take_shot = w_load && r_shot_pend;
  assign w_take_stat = w_load && !r_shot_pend && r_stat_pend;
  assign w_take_pos  = w_load && !r_shot_pend && !r_stat_pend && r_pos_pend;

  always_comb begin
    w_type = 8'h01;
    w_pl   = r_pos_pl;
    if (r_shot_pend) begin
      w_type = 8'h02;
      w_pl   = r_shot_pl;
    end else if (r_stat_pend) begin
      w_type = 8'h03;
      w_pl   = r_stat_pl;
    end
  end

  assign w_chk = w_type ^ w_pl[23:16] ^ w_pl[15:8] ^ w_pl[7:0];

  // A request on its own capture edge re-arms the flag and is not a drop.
  assign w_drop_n = {1'b0, bus.shot_req   && r_shot_pend && !w_take_shot}
                  + {1'b0, bus.status_req && r_stat_pend && !w_take_stat}
                  + {1'b0, bus.frame_tick && r_pos_pend  && !w_take_pos};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_any_pend) w_state_nx = S_SEND;
      end
      S_SEND: begin
        w_tx_data = r_pkt[r_idx];
        w_wr      = !bus.tx_full;
        if (w_wr && (r_idx == 3'd5)) w_state_nx = (MIN_GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_last_wr = w_wr && (r_idx == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_pend  <= 1'b0;
      r_shot_pend <= 1'b0;
      r_stat_pend <= 1'b0;
      r_pos_pl    <= '0;
      r_shot_pl   <= '0;
      r_stat_pl   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (bus.shot_req) begin
        r_shot_pend <= 1'b1;
        r_shot_pl   <= {bus.shot_x, bus.shot_y, 4'h0};
      end else if (w_take_shot) begin
        r_shot_pend <= 1'b0;
      end
      if (bus.status_req) begin
        r_stat_pend <= 1'b1;
        r_stat_pl   <= {bus.status_in, 16'h0000};
      end else if (w_take_stat) begin
        r_stat_pend <= 1'b0;
      end
      if (bus.frame_tick) begin
        r_pos_pend <= 1'b1;
        r_pos_pl   <= {bus.xpos_tank, bus.ypos_tank, 4'h0};
      end else if (w_take_pos) begin
        r_pos_pend <= 1'b0;
      end
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt      <= '0;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_pkt <= {w_chk, w_pl[7:0], w_pl[15:8], w_pl[23:16], w_type, SYNC_BYTE};
        r_idx <= '0;
      end else if (w_wr) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_last_wr) begin
        r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
      r_pkt_done <= w_last_wr;
    end
  end

  assign bus.tx_wr    = w_wr;
  assign bus.tx_data  = w_tx_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.pkt_done = r_pkt_done;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized requests
// checked against a packet-level reference model.
module tb_uart_tx_scheduler;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int wr_bad   = 0;
  logic [7:0] mon_b[$];
  int         mon_c[$];
  int         done_c[$];
  logic [7:0] exp_b[$];
  bit         busy_at[int];

  always #5 clk = ~clk;

  uart_tx_scheduler_if bus();

  uart_tx_scheduler #(.SYNC_BYTE(8'hA5), .MIN_GAP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_at[cyc] = bus.busy;
    if (rst_n) begin
      if (bus.tx_wr === 1'b1) begin
        mon_b.push_back(bus.tx_data);
        mon_c.push_back(cyc);
        if (bus.tx_full !== 1'b0 || bus.busy !== 1'b1) wr_bad++;
      end
      if (bus.pkt_done === 1'b1) done_c.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic end_pulse();
    tick();
    bus.frame_tick = 1'b0;
    bus.shot_req   = 1'b0;
    bus.status_req = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.frame_tick = 1'b0;
    bus.shot_req   = 1'b0;
    bus.status_req = 1'b0;
    bus.tx_full    = 1'b0;
    bus.xpos_tank  = '0;
    bus.ypos_tank  = '0;
    bus.shot_x     = '0;
    bus.shot_y     = '0;
    bus.status_in  = '0;
  endtask

  task automatic clear_mon();
    mon_b.delete();
    mon_c.delete();
    done_c.delete();
    exp_b.delete();
    wr_bad = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    clear_mon();
  endtask

  // Reference packet: SYNC, TYPE, 24-bit payload MSB first, XOR checksum.
  function automatic void push_pkt(input logic [7:0] t, input logic [23:0] pl);
    exp_b.push_back(8'hA5);
    exp_b.push_back(t);
    exp_b.push_back(pl[23:16]);
    exp_b.push_back(pl[15:8]);
    exp_b.push_back(pl[7:0]);
    exp_b.push_back(t ^ pl[23:16] ^ pl[15:8] ^ pl[7:0]);
  endfunction

  task automatic test_reset();
    clear_inputs();
    clear_mon();
    rst_n = 1'b0;
    tick(2);
    n_checks++;
    if ({bus.tx_data, bus.tx_wr, bus.busy, bus.pkt_done, bus.drop_cnt} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got data=%h wr=%b busy=%b done=%b drop=%0d, expected all zero",
               bus.tx_data, bus.tx_wr, bus.busy, bus.pkt_done, bus.drop_cnt);
    end
    rst_n = 1'b1;
    tick(10);
    n_checks++;
    if (mon_b.size() != 0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got %0d bytes busy=%b, expected 0 bytes busy=0", mon_b.size(), bus.busy);
    end
  endtask

  task automatic test_position();
    logic [7:0] lit[6] = '{8'hA5, 8'h01, 8'h55, 8'h4A, 8'hA0, 8'hBE};
    int n0;
    do_reset();
    bus.xpos_tank  = 10'h155;
    bus.ypos_tank  = 10'h0AA;
    bus.frame_tick = 1'b1;
    n0 = cyc;
    end_pulse();
    tick(16);
    n_checks++;
    if (mon_b.size() != 6) begin
      n_errors++;
      $display("FAIL pos_count: got %0d bytes, expected 6", mon_b.size());
    end
    for (int i = 0; i < 6 && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== lit[i] || mon_c[i] != n0 + 2 + i) begin
        n_errors++;
        $display("FAIL pos_byte%0d: got %h at cycle %0d, expected %h at cycle %0d",
                 i, mon_b[i], mon_c[i], lit[i], n0 + 2 + i);
      end
    end
    n_checks++;
    if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != n0 + 8)) begin
      n_errors++;
      $display("FAIL pos_pkt_done: got %0d pulses (first at %0d), expected 1 at cycle %0d",
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, n0 + 8);
    end
    n_checks++;
    if (busy_at[n0 + 11] !== 1'b1 || busy_at[n0 + 12] !== 1'b0) begin
      n_errors++;
      $display("FAIL pos_gap_busy: got busy %b,%b at gap end, expected 1,0",
               busy_at[n0 + 11], busy_at[n0 + 12]);
    end
  endtask

  task automatic test_priority();
    logic [7:0] lit[12] = '{8'hA5, 8'h02, 8'hFF, 8'hC0, 8'h00, 8'h3D,
                            8'hA5, 8'h03, 8'h5C, 8'h00, 8'h00, 8'h5F};
    logic [9:0] px, py;
    do_reset();
    px = 10'($urandom_range(0, 1023));
    py = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 12; i++) exp_b.push_back(lit[i]);
    push_pkt(8'h01, {px, py, 4'h0});
    bus.xpos_tank  = px;
    bus.ypos_tank  = py;
    bus.frame_tick = 1'b1;
    bus.shot_x     = 10'h3FF;
    bus.shot_y     = 10'h000;
    bus.shot_req   = 1'b1;
    bus.status_in  = 8'h5C;
    bus.status_req = 1'b1;
    end_pulse();
    tick(50);
    n_checks++;
    if (mon_b.size() != exp_b.size()) begin
      n_errors++;
      $display("FAIL prio_count: got %0d bytes, expected %0d", mon_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL prio_byte%0d: got %h, expected %h", i, mon_b[i], exp_b[i]);
      end
    end
    for (int i = 6; i < mon_c.size(); i += 6) begin
      n_checks++;
      if (mon_c[i] - mon_c[i-1] < 5) begin
        n_errors++;
        $display("FAIL prio_gap%0d: got %0d idle cycles, expected at least 4", i / 6, mon_c[i] - mon_c[i-1] - 1);
      end
    end
    n_checks++;
    if (done_c.size() != 3 || bus.drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL prio_done_drop: got %0d packets drop=%0d, expected 3 packets drop=0",
               done_c.size(), bus.drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] sx, sy;
    int n0;
    do_reset();
    sx = 10'($urandom_range(0, 1023));
    sy = 10'($urandom_range(0, 1023));
    push_pkt(8'h02, {sx, sy, 4'h0});
    bus.shot_x   = sx;
    bus.shot_y   = sy;
    bus.shot_req = 1'b1;
    n0 = cyc;
    end_pulse();
    tick(2);
    for (int k = 0; k < 10; k++) begin
      bus.tx_full = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.tx_wr !== 1'b0 || bus.tx_data !== 8'h02) begin
        n_errors++;
        $display("FAIL stall%0d: got wr=%b data=%h, expected wr=0 data=02", k, bus.tx_wr, bus.tx_data);
      end
      tick();
    end
    bus.tx_full = 1'b0;
    tick(20);
    n_checks++;
    if (mon_b.size() != 6 || wr_bad != 0) begin
      n_errors++;
      $display("FAIL bp_count: got %0d bytes %0d illegal writes, expected 6 bytes 0 illegal", mon_b.size(), wr_bad);
    end
    for (int i = 0; i < 6 && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL bp_byte%0d: got %h, expected %h", i, mon_b[i], exp_b[i]);
      end
    end
    n_checks++;
    if (mon_c.size() < 2 || mon_c[0] != n0 + 2 || mon_c[1] != n0 + 13) begin
      n_errors++;
      $display("FAIL bp_timing: got writes at %0d,%0d, expected %0d,%0d",
               (mon_c.size() > 0) ? mon_c[0] : -1, (mon_c.size() > 1) ? mon_c[1] : -1, n0 + 2, n0 + 13);
    end
  endtask

  task automatic test_coalesce();
    logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
    logic [9:0] sx, sy;
    do_reset();
    sx = 10'($urandom_range(0, 1023));
    sy = 10'($urandom_range(0, 1023));
    push_pkt(8'h02, {sx, sy, 4'h0});
    push_pkt(8'h03, {8'h33, 16'h0000});
    bus.shot_x   = sx;
    bus.shot_y   = sy;
    bus.shot_req = 1'b1;
    end_pulse();
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.status_in  = vals[i];
      bus.status_req = 1'b1;
      end_pulse();
      tick();
    end
    tick(40);
    n_checks++;
    if (mon_b.size() != exp_b.size() || bus.drop_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL coal_count: got %0d bytes drop=%0d, expected %0d bytes drop=2",
               mon_b.size(), bus.drop_cnt, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL coal_byte%0d: got %h, expected %h", i, mon_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int  mdrop = 0;
    bit  mpend = 1'b0;
    logic [9:0] sx, sy;
    do_reset();
    sx = 10'($urandom_range(0, 1023));
    sy = 10'($urandom_range(0, 1023));
    push_pkt(8'h02, {sx, sy, 4'h0});
    push_pkt(8'h03, {8'h2C, 16'h0000});
    bus.shot_x   = sx;
    bus.shot_y   = sy;
    bus.shot_req = 1'b1;
    bus.tx_full  = 1'b1;
    end_pulse();
    for (int k = 0; k < 301; k++) begin
      bus.status_in  = k[7:0];
      bus.status_req = 1'b1;
      end_pulse();
      if (mpend) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
      mpend = 1'b1;
      if (k % 50 == 0 || k == 255 || k == 300) begin
        n_checks++;
        if (bus.drop_cnt !== 8'(mdrop)) begin
          n_errors++;
          $display("FAIL sat_drop_k%0d: got %0d, expected %0d", k, bus.drop_cnt, mdrop);
        end
      end
      tick();
    end
    bus.tx_full = 1'b0;
    tick(40);
    n_checks++;
    if (mon_b.size() != exp_b.size() || bus.drop_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL sat_final: got %0d bytes drop=%0d, expected %0d bytes drop=255",
               mon_b.size(), bus.drop_cnt, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL sat_byte%0d: got %h, expected %h", i, mon_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] px, py, sx, sy;
    do_reset();
    px = 10'($urandom_range(0, 1023));
    py = 10'($urandom_range(0, 1023));
    sx = 10'($urandom_range(0, 1023));
    sy = 10'($urandom_range(0, 1023));
    bus.xpos_tank  = px;
    bus.ypos_tank  = py;
    bus.frame_tick = 1'b1;
    end_pulse();
    bus.status_in  = 8'h77;
    bus.status_req = 1'b1;
    end_pulse();
    bus.status_req = 1'b1;
    end_pulse();
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.tx_data, bus.tx_wr, bus.busy, bus.pkt_done, bus.drop_cnt} !== 19'd0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got data=%h wr=%b busy=%b done=%b drop=%0d, expected all zero",
               bus.tx_data, bus.tx_wr, bus.busy, bus.pkt_done, bus.drop_cnt);
    end
    n_checks++;
    if (mon_b.size() != 3) begin
      n_errors++;
      $display("FAIL mid_reset_bytes: got %0d bytes before reset, expected 3", mon_b.size());
    end
    tick(2);
    rst_n = 1'b1;
    tick(30);
    n_checks++;
    if (mon_b.size() != 3 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_quiet: got %0d bytes busy=%b, expected 3 bytes busy=0", mon_b.size(), bus.busy);
    end
    push_pkt(8'h01, {px, py, 4'h0});
    repeat (3) void'(exp_b.pop_back());
    push_pkt(8'h02, {sx, sy, 4'h0});
    bus.shot_x   = sx;
    bus.shot_y   = sy;
    bus.shot_req = 1'b1;
    end_pulse();
    tick(15);
    n_checks++;
    if (mon_b.size() != exp_b.size()) begin
      n_errors++;
      $display("FAIL mid_reset_count: got %0d bytes, expected %0d", mon_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL mid_reset_byte%0d: got %h, expected %h", i, mon_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [9:0] ax, ay, bx, by;
    int n0;
    do_reset();
    ax = 10'($urandom_range(0, 1023));
    ay = 10'($urandom_range(0, 1023));
    bx = ax ^ 10'h2A5;
    by = ay ^ 10'h15A;
    push_pkt(8'h02, {ax, ay, 4'h0});
    push_pkt(8'h02, {bx, by, 4'h0});
    bus.shot_x   = ax;
    bus.shot_y   = ay;
    bus.shot_req = 1'b1;
    n0 = cyc;
    tick();
    bus.shot_x = bx;
    bus.shot_y = by;
    end_pulse();
    tick(35);
    n_checks++;
    if (mon_b.size() != exp_b.size() || bus.drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL bnd_count: got %0d bytes drop=%0d, expected %0d bytes drop=0",
               mon_b.size(), bus.drop_cnt, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < mon_b.size(); i++) begin
      n_checks++;
      if (mon_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL bnd_byte%0d: got %h, expected %h", i, mon_b[i], exp_b[i]);
      end
    end
    n_checks++;
    if (mon_c.size() == 0 || mon_c[0] != n0 + 2) begin
      n_errors++;
      $display("FAIL bnd_latency: got first write at %0d, expected %0d",
               (mon_c.size() > 0) ? mon_c[0] : -1, n0 + 2);
    end
  endtask

  task automatic test_random();
    logic [9:0] px, py, sx, sy;
    logic [7:0] st;
    int mask, npkt;
    do_reset();
    for (int it = 0; it < 15; it++) begin
      clear_mon();
      mask = $urandom_range(1, 7);
      px = 10'($urandom_range(0, 1023));
      py = 10'($urandom_range(0, 1023));
      sx = 10'($urandom_range(0, 1023));
      sy = 10'($urandom_range(0, 1023));
      st = 8'($urandom_range(0, 255));
      npkt = 0;
      if (mask & 1) begin push_pkt(8'h02, {sx, sy, 4'h0}); npkt++; end
      if (mask & 2) begin push_pkt(8'h03, {st, 16'h0000}); npkt++; end
      if (mask & 4) begin push_pkt(8'h01, {px, py, 4'h0}); npkt++; end
      bus.shot_x     = sx;
      bus.shot_y     = sy;
      bus.status_in  = st;
      bus.xpos_tank  = px;
      bus.ypos_tank  = py;
      bus.shot_req   = (mask & 1) != 0;
      bus.status_req = (mask & 2) != 0;
      bus.frame_tick = (mask & 4) != 0;
      end_pulse();
      for (int c = 0; c < 400 && mon_b.size() < exp_b.size(); c++) begin
        bus.tx_full = ($urandom_range(0, 2) == 0);
        tick();
      end
      bus.tx_full = 1'b0;
      tick(14);
      n_checks++;
      if (mon_b.size() != exp_b.size() || done_c.size() != npkt || wr_bad != 0) begin
        n_errors++;
        $display("FAIL rnd%0d_count: got %0d bytes %0d packets %0d illegal, expected %0d bytes %0d packets 0 illegal",
                 it, mon_b.size(), done_c.size(), wr_bad, exp_b.size(), npkt);
      end
      for (int i = 0; i < exp_b.size() && i < mon_b.size(); i++) begin
        n_checks++;
        if (mon_b[i] !== exp_b[i]) begin
          n_errors++;
          $display("FAIL rnd%0d_byte%0d: got %h, expected %h", it, i, mon_b[i], exp_b[i]);
        end
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.drop_cnt !== 8'd0) begin
        n_errors++;
        $display("FAIL rnd%0d_idle: got busy=%b drop=%0d, expected busy=0 drop=0", it, bus.busy, bus.drop_cnt);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_position();
    test_priority();
    test_backpressure();
    test_coalesce();
    test_saturate();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
